ptr_alloc_arbiter: RTL and testbench
====================================

# ptr_alloc_arbiter

Shares the switch's free-pointer queue between N_ALLOC cell-buffer writers, which allocate 10-bit cell addresses, and N_REL output schedulers, which release them. Each direction uses a round-robin arbiter, with at most one pop and one push per cycle. After reset the block holds off traffic until the free queue has finished self-initialisation. It also keeps an in-use count for flow control and diagnostics.

## Interface
- N_ALLOC, 4, number of allocating requesters
- N_REL, 4, number of releasing requesters
- PTR_W, 10, pointer width
- PTR_TOTAL, 511, pointers the free queue holds after initialisation
- INIT_CYCLES, 520, cycles after reset before the free queue accepts pushes
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- alloc_req  in  N_ALLOC  per-requester allocation request, held until acked
- alloc_ack  out  N_ALLOC  one-hot, one-cycle pulse, registered
- alloc_ptr  out  PTR_W  allocated pointer, valid only while alloc_ack≠0
- rel_req  in  N_REL  per-requester release request, held until acked
- rel_ptr  in  N_REL*PTR_W  release pointer; requester i uses bits [i*PTR_W +: PTR_W]
- rel_ack  out  N_REL  one-hot, one-cycle pulse, registered
- fq_rd  out  1  pop strobe to the free queue (combinational)
- fq_dout  in  PTR_W  free-queue head; the queue is first-word-fall-through
- fq_empty  in  1  free queue empty
- fq_wr  out  1  push strobe to the free queue, registered
- fq_din  out  16  pushed pointer in [PTR_W-1:0]; upper bits are 0
- ready  out  1  high once initialisation has completed
- used_cnt  out  PTR_W  number of pointers currently allocated
- err_underflow  out  1  sticky flag: a release arrived while used_cnt==0

## Operation
- **States**
  - INIT: an init counter counts 0..INIT_CYCLES-1. No grants are made in either direction.
  - INIT → RUN when the counter reaches INIT_CYCLES-1. In RUN, ready=1.
  - RUN is left only by reset.
- **Allocation arbiter** (RUN only)
  - Eligible set = alloc_req & ~alloc_ack. This excludes a requester in its ack cycle.
  - A grant is issued when eligible≠0 and fq_empty=0.
  - The winner is the first eligible index strictly after alloc_last, searching upward with wrap.
  - On grant:
    - fq_rd=1 in the same cycle.
    - fq_dout is registered into alloc_ptr.
    - alloc_ack[winner]=1 on the next cycle.
    - alloc_last ← winner.
  - fq_empty=1: no grant and fq_rd=0. Requests stay pending.
- **Release arbiter** (RUN only)
  - Same round-robin scheme on rel_req & ~rel_ack, using rel_last.
  - The free queue is never refused; there is no full check, because pushes never exceed pops.
  - On grant, next cycle:
    - fq_wr=1.
    - fq_din={6'b0, rel_ptr[winner]}.
    - rel_ack[winner]=1.
  - If used_cnt==0 at grant time:
    - The release is still acked.
    - fq_wr stays 0 (pointer discarded).
    - err_underflow is set.
- **used_cnt**
  - +1 on an allocation grant; −1 on a release grant that is pushed.
  - Both in the same cycle: unchanged.
  - Can never exceed PTR_TOTAL, since allocation is gated by fq_empty.
- **Independence:** the allocation and release paths run independently and may both grant in the same cycle.

## Timing
- **Reset values** (all outputs 0): alloc_ack, alloc_ptr, rel_ack, fq_wr, fq_din, ready, used_cnt, err_underflow. The combinational fq_rd is also 0 while in reset.
- alloc_last and rel_last reset to N-1, so index 0 has first priority.
- **Reset mid-operation:**
  - Returns to INIT and restarts the init counter.
  - In-flight acks are dropped; requesters must re-request.
  - The free queue is reset by the same rst.
- **Allocate latency:** request sampled at cycle t → fq_rd at t → alloc_ack and alloc_ptr at t+1.
- **Release latency:** request at t → fq_wr, fq_din and rel_ack at t+1.
- Sustained throughput: one allocation plus one release per cycle.
- A requester holding req continuously is granted at most every other cycle.
- ready rises on the cycle after the counter reaches INIT_CYCLES-1. With the default, the first possible fq_rd is cycle 520 after reset release.

## Test plan
- **Init hold-off:** hold all alloc_req and rel_req high from reset release. Required: fq_rd=0, fq_wr=0, all acks 0 for 520 cycles; ready=1 from cycle 520; first alloc_ack at req[0] on cycle 521.
- **Round-robin fairness:** hold alloc_req=4'b1111 with a non-empty queue. Required: ack order 0,1,2,3,0,…; alloc_ptr equals successive fq_dout values; used_cnt increments per grant.
- **Empty stall:** force fq_empty=1 with alloc_req=4'b0100. Required: no fq_rd, no ack. Deassert fq_empty. Required: fq_rd the same cycle, alloc_ack=4'b0100 the next cycle.
- **Simultaneous traffic:** used_cnt=5; alloc_req[1] and rel_req[2] with rel_ptr[2]=10'h03A in the same cycle. Required: one cycle later alloc_ack=4'b0010, rel_ack=4'b0100, fq_wr=1, fq_din=16'h003A, used_cnt stays 5.
- **Underflow:** rel_req[0] with used_cnt=0. Required: rel_ack[0] pulses, fq_wr=0, err_underflow=1 and stays 1 until reset.
- **Mid-run reset:** assert rst during an active allocation grant. Required: all outputs 0 immediately, ready=0, then a full 520-cycle INIT before any grant.

Source files
------------

// File: rtl/ptr_alloc_arbiter.sv
// Free-pointer queue sharing: round-robin allocation (pop) and release (push)
// arbiters, init hold-off after reset, and an in-use pointer count.

module ptr_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] win
);
    logic [IW-1:0] idx;

    // First eligible index strictly after 'last', searching upward with wrap.
    always_comb begin
        any = 1'b0;
        win = last;
        idx = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(last) + i) % N);
            if (!any && elig[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end
endmodule

module ptr_alloc_arbiter #(
    parameter int N_ALLOC     = 4,
    parameter int N_REL       = 4,
    parameter int PTR_W       = 10,
    parameter int PTR_TOTAL   = 511,
    parameter int INIT_CYCLES = 520
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_ALLOC-1:0]     alloc_req,
    output logic [N_ALLOC-1:0]     alloc_ack,
    output logic [PTR_W-1:0]       alloc_ptr,
    input  logic [N_REL-1:0]       rel_req,
    input  logic [N_REL*PTR_W-1:0] rel_ptr,
    output logic [N_REL-1:0]       rel_ack,
    output logic                   fq_rd,
    input  logic [PTR_W-1:0]       fq_dout,
    input  logic                   fq_empty,
    output logic                   fq_wr,
    output logic [15:0]            fq_din,
    output logic                   ready,
    output logic [PTR_W-1:0]       used_cnt,
    output logic                   err_underflow
);
    localparam int AW = (N_ALLOC > 1) ? $clog2(N_ALLOC) : 1;
    localparam int RW = (N_REL > 1) ? $clog2(N_REL) : 1;
    localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] init_cnt;
    logic          run;

    logic [N_ALLOC-1:0] alloc_elig;
    logic [AW-1:0]      alloc_last, a_win;
    logic               a_any, alloc_gnt;

    logic [N_REL-1:0] rel_elig;
    logic [RW-1:0]    rel_last, r_win;
    logic             r_any, rel_gnt, rel_push;
    logic [PTR_W-1:0] rel_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_INIT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && init_cnt == CW'(INIT_CYCLES - 1))
            state_nxt = S_RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            init_cnt <= '0;
        else if (state == S_INIT && init_cnt != CW'(INIT_CYCLES - 1))
            init_cnt <= init_cnt + 1'b1;
    end

    assign run   = (state == S_RUN);
    assign ready = run;

    // A requester in its ack cycle is masked so a held request cannot win twice in a row.
    assign alloc_elig = alloc_req & ~alloc_ack;
    assign rel_elig   = rel_req & ~rel_ack;

    ptr_rr_pick #(.N(N_ALLOC), .IW(AW)) u_alloc_pick (
        .elig(alloc_elig), .last(alloc_last), .any(a_any), .win(a_win)
    );

    ptr_rr_pick #(.N(N_REL), .IW(RW)) u_rel_pick (
        .elig(rel_elig), .last(rel_last), .any(r_any), .win(r_win)
    );

    assign alloc_gnt = run && a_any && !fq_empty;
    assign fq_rd     = alloc_gnt;
    assign rel_gnt   = run && r_any;
    assign rel_push  = rel_gnt && (used_cnt != '0);
    assign rel_sel   = rel_ptr[r_win*PTR_W +: PTR_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_ack  <= '0;
            alloc_ptr  <= '0;
            alloc_last <= AW'(N_ALLOC - 1);
        end else begin
            alloc_ack <= '0;
            if (alloc_gnt) begin
                alloc_ack[a_win] <= 1'b1;
                alloc_ptr        <= fq_dout;
                alloc_last       <= a_win;
            end
        end
    end

    // A release with nothing allocated is acked but dropped, never pushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rel_ack       <= '0;
            rel_last      <= RW'(N_REL - 1);
            fq_wr         <= 1'b0;
            fq_din        <= '0;
            err_underflow <= 1'b0;
        end else begin
            rel_ack <= '0;
            fq_wr   <= 1'b0;
            if (rel_gnt) begin
                rel_ack[r_win] <= 1'b1;
                rel_last       <= r_win;
                if (rel_push) begin
                    fq_wr  <= 1'b1;
                    fq_din <= 16'(rel_sel);
                end else begin
                    err_underflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            used_cnt <= '0;
        else begin
            case ({alloc_gnt, rel_push})
                2'b10:   used_cnt <= used_cnt + 1'b1;
                2'b01:   used_cnt <= used_cnt - 1'b1;
                default: used_cnt <= used_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_ptr_alloc_arbiter.sv
// Directed bench for ptr_alloc_arbiter with a small FWFT free-queue model
// preloaded with pointers 1..511 on every reset.

module tb_ptr_alloc_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  alloc_req = '0;
    logic [3:0]  alloc_ack;
    logic [9:0]  alloc_ptr;
    logic [3:0]  rel_req = '0;
    logic [39:0] rel_ptr = '0;
    logic [3:0]  rel_ack;
    logic        fq_rd;
    logic [9:0]  fq_dout;
    logic        fq_empty;
    logic        fq_wr;
    logic [15:0] fq_din;
    logic        ready;
    logic [9:0]  used_cnt;
    logic        err_underflow;

    logic        force_empty = 1'b0;
    logic        q_empty;
    logic [9:0]  q[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ptr_alloc_arbiter dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_ptr(alloc_ptr),
        .rel_req(rel_req), .rel_ptr(rel_ptr), .rel_ack(rel_ack),
        .fq_rd(fq_rd), .fq_dout(fq_dout), .fq_empty(fq_empty),
        .fq_wr(fq_wr), .fq_din(fq_din), .ready(ready),
        .used_cnt(used_cnt), .err_underflow(err_underflow)
    );

    assign fq_empty = q_empty | force_empty;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            for (int i = 0; i < 511; i++) q.push_back(10'(i + 1));
            fq_dout <= 10'd1;
            q_empty <= 1'b0;
        end else begin
            if (fq_rd && q.size() > 0) void'(q.pop_front());
            if (fq_wr) q.push_back(fq_din[9:0]);
            fq_dout <= (q.size() > 0) ? q[0] : 10'd0;
            q_empty <= (q.size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int bad;

    initial begin
        // Init hold-off with every requester asserted from reset release
        alloc_req = 4'hF;
        rel_req   = 4'hF;
        rel_ptr   = {10'h3FF, 10'h3FE, 10'h3FD, 10'h3FC};
        #1;
        chk("reset_fq_rd", fq_rd, 0);
        chk("reset_ready", ready, 0);
        chk("reset_outputs", {alloc_ack, rel_ack, fq_wr, err_underflow}, 0);
        chk("reset_data", {alloc_ptr, fq_din, used_cnt}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 520; k++) begin
            #1;
            if (fq_rd || fq_wr || alloc_ack != 0 || rel_ack != 0 || ready) bad++;
            tick();
        end
        chk("init_holdoff_quiet", bad, 0);
        chk("init_ready_520", ready, 1);
        chk("init_fq_rd_520", fq_rd, 1);
        tick();
        chk("init_alloc_ack_521", alloc_ack, 4'b0001);
        chk("init_alloc_ptr_521", alloc_ptr, 10'h001);
        chk("underflow_rel_ack", rel_ack, 4'b0001);
        chk("underflow_no_wr", fq_wr, 0);
        chk("underflow_flag", err_underflow, 1);
        chk("used_after_first", used_cnt, 1);
        alloc_req = 4'h0;
        rel_req   = 4'h0;
        tick();
        chk("rel_ack_pulse_end", rel_ack, 0);
        chk("underflow_sticky", err_underflow, 1);

        // Round-robin: last winner was 0, so order continues 1,2,3,0,1
        alloc_req = 4'hF;
        tick(); chk("rr1_ack", alloc_ack, 4'b0010); chk("rr1_ptr", alloc_ptr, 10'h002); chk("rr1_used", used_cnt, 2);
        tick(); chk("rr2_ack", alloc_ack, 4'b0100); chk("rr2_ptr", alloc_ptr, 10'h003); chk("rr2_used", used_cnt, 3);
        tick(); chk("rr3_ack", alloc_ack, 4'b1000); chk("rr3_ptr", alloc_ptr, 10'h004); chk("rr3_used", used_cnt, 4);
        tick(); chk("rr4_ack", alloc_ack, 4'b0001); chk("rr4_ptr", alloc_ptr, 10'h005); chk("rr4_used", used_cnt, 5);
        tick(); chk("rr5_ack", alloc_ack, 4'b0010); chk("rr5_ptr", alloc_ptr, 10'h006); chk("rr5_used", used_cnt, 6);
        alloc_req = 4'h0;

        // Empty stall
        tick();
        force_empty = 1'b1;
        alloc_req   = 4'b0100;
        #1 chk("empty_no_rd", fq_rd, 0);
        tick(); chk("empty_no_ack1", alloc_ack, 0);
        tick(); chk("empty_no_ack2", alloc_ack, 0); chk("empty_used", used_cnt, 6);
        force_empty = 1'b0;
        #1 chk("unempty_rd", fq_rd, 1);
        tick();
        chk("unempty_ack", alloc_ack, 4'b0100);
        chk("unempty_ptr", alloc_ptr, 10'h007);
        chk("unempty_used", used_cnt, 7);
        alloc_req = 4'h0;

        // Two pushing releases bring used_cnt to 5
        rel_req = 4'b0010;
        rel_ptr[1*10 +: 10] = 10'h155;
        tick();
        chk("rel1_ack", rel_ack, 4'b0010); chk("rel1_wr", fq_wr, 1);
        chk("rel1_din", fq_din, 16'h0155); chk("rel1_used", used_cnt, 6);
        rel_req = 4'b1000;
        rel_ptr[3*10 +: 10] = 10'h2AA;
        tick();
        chk("rel2_ack", rel_ack, 4'b1000); chk("rel2_din", fq_din, 16'h02AA); chk("rel2_used", used_cnt, 5);

        // Simultaneous allocate and release
        alloc_req = 4'b0010;
        rel_req   = 4'b0100;
        rel_ptr[2*10 +: 10] = 10'h03A;
        tick();
        chk("sim_alloc_ack", alloc_ack, 4'b0010);
        chk("sim_alloc_ptr", alloc_ptr, 10'h008);
        chk("sim_rel_ack", rel_ack, 4'b0100);
        chk("sim_wr", fq_wr, 1);
        chk("sim_din", fq_din, 16'h003A);
        chk("sim_used", used_cnt, 5);

        // Mid-run reset during an allocation ack
        alloc_req = 4'b0001;
        rel_req   = 4'b0000;
        tick();
        chk("pre_rst_ack", alloc_ack, 4'b0001);
        chk("pre_rst_wr", fq_wr, 0);
        chk("pre_rst_used", used_cnt, 6);
        rst = 1'b0;
        #1;
        chk("mid_rst_acks", {alloc_ack, rel_ack}, 0);
        chk("mid_rst_data", {alloc_ptr, fq_din, used_cnt}, 0);
        chk("mid_rst_flags", {fq_wr, fq_rd, ready, err_underflow}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 520; k++) begin
            #1;
            if (fq_rd || fq_wr || alloc_ack != 0 || rel_ack != 0 || ready) bad++;
            tick();
        end
        chk("reinit_holdoff_quiet", bad, 0);
        chk("reinit_ready", ready, 1);
        chk("reinit_fq_rd", fq_rd, 1);
        tick();
        chk("reinit_ack", alloc_ack, 4'b0001);
        chk("reinit_ptr", alloc_ptr, 10'h001);
        chk("reinit_used", used_cnt, 1);
        chk("reinit_no_underflow", err_underflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
